// File: rtl/rv32_mul_shift_unit_if.sv
// Request/result handshake plus multiplier IP port of the shift unit.
// The slave modport is the unit; master is the surrounding pipeline and multiplier.
interface rv32_mul_shift_unit_if #(
   parameter int XLEN  = 32,
   parameter int MUL_W = 16
);
   logic                 i_valid;
   logic                 o_ready;
   logic [2:0]           i_op;
   logic [XLEN-1:0]      i_operand_one;
   logic [XLEN-1:0]      i_operand_two;
   logic                 i_flush;
   logic                 o_valid;
   logic                 i_ready;
   logic [XLEN-1:0]      o_result;
   logic                 o_illegal;
   logic                 o_mul_req;
   logic [MUL_W-1:0]     o_mul_operand_one;
   logic [MUL_W-1:0]     o_mul_operand_two;
   logic                 i_mul_valid;
   logic [2*MUL_W-1:0]   i_mul_result;

   modport slave (
      input  i_valid, i_op, i_operand_one, i_operand_two, i_flush, i_ready,
             i_mul_valid, i_mul_result,
      output o_ready, o_valid, o_result, o_illegal,
             o_mul_req, o_mul_operand_one, o_mul_operand_two
   );

   modport master (
      output i_valid, i_op, i_operand_one, i_operand_two, i_flush, i_ready,
             i_mul_valid, i_mul_result,
      input  o_ready, o_valid, o_result, o_illegal,
             o_mul_req, o_mul_operand_one, o_mul_operand_two
   );
endinterface

// File: rtl/rv32_mul_shift_unit.sv
// Multicycle shift/rotate unit: every shift is a multiply by 2^k, done one
// limb of the double-width extended operand at a time on a narrow multiplier.
module rv32_mul_shift_unit #(
   parameter int XLEN  = 32,
   parameter int MUL_W = 16
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   rv32_mul_shift_unit_if.slave bus
);
   localparam int SHAMT_W = $clog2(XLEN);
   localparam int NLIMB   = 2 * XLEN / MUL_W;
   localparam int IDX_W   = (NLIMB > 2) ? $clog2(NLIMB) : 1;
   localparam int R_W     = (MUL_W > 2) ? $clog2(MUL_W) : 1;
   localparam int W2      = 2 * XLEN;

   localparam logic [2:0] OP_SLL = 3'd0;
   localparam logic [2:0] OP_SRL = 3'd1;
   localparam logic [2:0] OP_SRA = 3'd2;
   localparam logic [2:0] OP_ROL = 3'd3;
   localparam logic [2:0] OP_ROR = 3'd4;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_GAP   = 2'd2,
      S_DONE  = 2'd3
   } state_e;

   state_e           state_q, state_d;
   logic [2:0]       op_q, op_d;
   logic [W2-1:0]    ext_q, ext_d;
   logic [W2-1:0]    acc_q, acc_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [IDX_W-1:0] j0_q, j0_d;
   logic [MUL_W-1:0] mul_a_q, mul_a_d;
   logic [MUL_W-1:0] mul_b_q, mul_b_d;
   logic [XLEN-1:0]  result_q, result_d;
   logic             illegal_q, illegal_d;

   logic [SHAMT_W-1:0] s_s;
   logic [31:0]        k_s;
   logic [IDX_W-1:0]   j0_s;
   logic [R_W-1:0]     r_s;
   logic               op_illegal_s;
   logic [W2-1:0]      ext_s;
   logic [W2-1:0]      acc_add_s;
   logic [W2-1:0]      acc_sum_s;
   logic [IDX_W-1:0]   last_idx_s;

   function automatic logic [MUL_W-1:0] limb_of(input logic [W2-1:0] ext,
                                                input logic [IDX_W-1:0] idx);
      return MUL_W'(ext >> (32'(idx) * 32'(MUL_W)));
   endfunction

   // Left shifts keep the low half of the product; right shifts the high half;
   // rotates fold the bits pushed out back into the low half.
   function automatic logic [XLEN-1:0] pick_result(input logic [2:0] op,
                                                   input logic [W2-1:0] acc);
      logic [XLEN-1:0] res;
      case (op)
         OP_SLL:         res = acc[XLEN-1:0];
         OP_SRL, OP_SRA: res = acc[W2-1:XLEN];
         OP_ROL, OP_ROR: res = acc[XLEN-1:0] | acc[W2-1:XLEN];
         default:        res = {XLEN{1'b0}};
      endcase
      return res;
   endfunction

   // Accept-time decode of shift amount, power-of-two factor and extension
   always_comb begin
      s_s          = bus.i_operand_two[SHAMT_W-1:0];
      op_illegal_s = (bus.i_op > OP_ROR);
      if ((bus.i_op == OP_SLL) || (bus.i_op == OP_ROL)) begin
         k_s = 32'(s_s);
      end else begin
         k_s = 32'(XLEN) - 32'(s_s);
      end
      j0_s = IDX_W'(k_s / 32'(MUL_W));
      r_s  = R_W'(k_s % 32'(MUL_W));
      if (bus.i_op == OP_SRA) begin
         ext_s = {{XLEN{bus.i_operand_one[XLEN-1]}}, bus.i_operand_one};
      end else begin
         ext_s = {{XLEN{1'b0}}, bus.i_operand_one};
      end
   end

   // Accumulation of one partial product and the last-limb index
   always_comb begin
      acc_add_s  = W2'(bus.i_mul_result) << (32'(idx_q + j0_q) * 32'(MUL_W));
      acc_sum_s  = acc_q + acc_add_s;
      last_idx_s = IDX_W'(NLIMB - 1) - j0_q;
   end

   // Next-state and datapath update
   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      ext_d     = ext_q;
      acc_d     = acc_q;
      idx_d     = idx_q;
      j0_d      = j0_q;
      mul_a_d   = mul_a_q;
      mul_b_d   = mul_b_q;
      result_d  = result_q;
      illegal_d = illegal_q;
      if (bus.i_flush) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (bus.i_valid) begin
                  op_d      = bus.i_op;
                  ext_d     = ext_s;
                  j0_d      = j0_s;
                  idx_d     = {IDX_W{1'b0}};
                  acc_d     = {W2{1'b0}};
                  illegal_d = op_illegal_s;
                  mul_a_d   = ext_s[MUL_W-1:0];
                  mul_b_d   = MUL_W'(1'b1) << r_s;
                  if (op_illegal_s) begin
                     state_d  = S_DONE;
                     result_d = {XLEN{1'b0}};
                  end else if (s_s == {SHAMT_W{1'b0}}) begin
                     state_d  = S_DONE;
                     result_d = bus.i_operand_one;
                  end else begin
                     state_d = S_ISSUE;
                  end
               end else begin
                  state_d = S_IDLE;
               end
            end
            S_ISSUE: begin
               if (bus.i_mul_valid) begin
                  acc_d = acc_sum_s;
                  idx_d = idx_q + IDX_W'(1'b1);
                  if (idx_q == last_idx_s) begin
                     state_d  = S_DONE;
                     result_d = pick_result(op_q, acc_sum_s);
                  end else begin
                     state_d = S_GAP;
                  end
               end else begin
                  state_d = S_ISSUE;
               end
            end
            S_GAP: begin
               state_d = S_ISSUE;
               mul_a_d = limb_of(ext_q, idx_q);
            end
            S_DONE: begin
               if (bus.i_ready) begin
                  state_d = S_IDLE;
               end else begin
                  state_d = S_DONE;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // State and datapath registers
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q   <= S_IDLE;
         op_q      <= 3'd0;
         ext_q     <= {W2{1'b0}};
         acc_q     <= {W2{1'b0}};
         idx_q     <= {IDX_W{1'b0}};
         j0_q      <= {IDX_W{1'b0}};
         mul_a_q   <= {MUL_W{1'b0}};
         mul_b_q   <= {MUL_W{1'b0}};
         result_q  <= {XLEN{1'b0}};
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         ext_q     <= ext_d;
         acc_q     <= acc_d;
         idx_q     <= idx_d;
         j0_q      <= j0_d;
         mul_a_q   <= mul_a_d;
         mul_b_q   <= mul_b_d;
         result_q  <= result_d;
         illegal_q <= illegal_d;
      end
   end

   assign bus.o_ready           = (state_q == S_IDLE);
   assign bus.o_valid           = (state_q == S_DONE);
   assign bus.o_mul_req         = (state_q == S_ISSUE);
   assign bus.o_mul_operand_one = mul_a_q;
   assign bus.o_mul_operand_two = mul_b_q;
   assign bus.o_result          = result_q;
   assign bus.o_illegal         = illegal_q;
endmodule

// File: tb/tb_rv32_mul_shift_unit.sv
// Directed bench for rv32_mul_shift_unit with a one-cycle multiplier model.
module tb_rv32_mul_shift_unit;
   logic clk = 1'b0;
   logic rst_n;
   int   n_cmp = 0;
   int   n_fail = 0;
   int   age = 0;
   int   txn_total = 0;
   int   reqc_total = 0;
   logic auto_valid = 1'b0;
   logic inject = 1'b0;
   logic [15:0] last_b = 16'h0;

   rv32_mul_shift_unit_if bus ();
   rv32_mul_shift_unit dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));

   always #5 clk = ~clk;
   assign bus.i_mul_valid = auto_valid | inject;

   // Multiplier model: product pulse on the second cycle of each request
   always @(negedge clk) begin
      if (bus.o_mul_req) begin
         age        = age + 1;
         reqc_total = reqc_total + 1;
      end else begin
         age = 0;
      end
      auto_valid = (age == 2);
      if (age == 2) begin
         txn_total = txn_total + 1;
         last_b    = bus.o_mul_operand_two;
      end
      bus.i_mul_result = 32'(bus.o_mul_operand_one) * 32'(bus.o_mul_operand_two);
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      int w = 0;
      while (!bus.o_ready && w < 50) begin
         @(negedge clk);
         w++;
      end
      chk("ready_before_accept", 64'(bus.o_ready), 64'd1);
      bus.i_valid       = 1'b1;
      bus.i_op          = op;
      bus.i_operand_one = a;
      bus.i_operand_two = b;
      @(negedge clk);
      bus.i_valid = 1'b0;
   endtask

   task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output int txn, output int reqc);
      int t0 = txn_total;
      int q0 = reqc_total;
      start_op(op, a, b);
      lat = 1;
      while (!bus.o_valid && lat < 300) begin
         @(negedge clk);
         lat++;
      end
      txn  = txn_total - t0;
      reqc = reqc_total - q0;
   endtask

   int lat, txn, reqc, vcnt;

   initial begin
      rst_n             = 1'b0;
      bus.i_valid       = 1'b0;
      bus.i_op          = 3'd0;
      bus.i_operand_one = 32'h0;
      bus.i_operand_two = 32'h0;
      bus.i_flush       = 1'b0;
      bus.i_ready       = 1'b1;
      bus.i_mul_result  = 32'h0;
      @(negedge clk);
      @(negedge clk);
      chk("rst_ready", 64'(bus.o_ready), 64'd1);
      chk("rst_valid", 64'(bus.o_valid), 64'd0);
      chk("rst_mul_req", 64'(bus.o_mul_req), 64'd0);
      chk("rst_result", 64'(bus.o_result), 64'd0);
      chk("rst_illegal", 64'(bus.o_illegal), 64'd0);
      chk("rst_mul_a", 64'(bus.o_mul_operand_one), 64'd0);
      chk("rst_mul_b", 64'(bus.o_mul_operand_two), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // SLL 1 by 4: k=4, four transactions of three cycles each
      run_op(3'b000, 32'h0000_0001, 32'd4, lat, txn, reqc);
      chk("sll_result", 64'(bus.o_result), 64'h0000_0010);
      chk("sll_illegal", 64'(bus.o_illegal), 64'd0);
      chk("sll_txn", 64'(txn), 64'd4);
      chk("sll_factor", 64'(last_b), 64'h0010);
      chk("sll_latency", 64'(lat), 64'd12);
      @(negedge clk);
      chk("sll_ready_after", 64'(bus.o_ready), 64'd1);

      run_op(3'b010, 32'h8000_0000, 32'd31, lat, txn, reqc);
      chk("sra_result", 64'(bus.o_result), 64'hFFFF_FFFF);
      chk("sra_txn", 64'(txn), 64'd4);
      @(negedge clk);

      run_op(3'b001, 32'h8000_0000, 32'd31, lat, txn, reqc);
      chk("srl_result", 64'(bus.o_result), 64'h0000_0001);
      @(negedge clk);

      // ROR 1 by 1: k=31, j0=1, three transactions
      run_op(3'b100, 32'h0000_0001, 32'd1, lat, txn, reqc);
      chk("ror_result", 64'(bus.o_result), 64'h8000_0000);
      chk("ror_txn", 64'(txn), 64'd3);
      chk("ror_latency", 64'(lat), 64'd9);
      @(negedge clk);

      run_op(3'b011, 32'h8000_0001, 32'd4, lat, txn, reqc);
      chk("rol_result", 64'(bus.o_result), 64'h0000_0018);
      @(negedge clk);

      // Upper bits of operand_two are ignored: 32 acts as a zero shift
      run_op(3'b001, 32'hDEAD_BEEF, 32'd0, lat, txn, reqc);
      chk("bypass_result", 64'(bus.o_result), 64'hDEAD_BEEF);
      chk("bypass_illegal", 64'(bus.o_illegal), 64'd0);
      chk("bypass_latency", 64'(lat), 64'd1);
      chk("bypass_no_req", 64'(reqc), 64'd0);
      @(negedge clk);

      run_op(3'b000, 32'hDEAD_BEEF, 32'd32, lat, txn, reqc);
      chk("shamt_mask_result", 64'(bus.o_result), 64'hDEAD_BEEF);
      @(negedge clk);

      run_op(3'b111, 32'hDEAD_BEEF, 32'd5, lat, txn, reqc);
      chk("illegal_result", 64'(bus.o_result), 64'd0);
      chk("illegal_flag", 64'(bus.o_illegal), 64'd1);
      chk("illegal_latency", 64'(lat), 64'd1);
      chk("illegal_no_req", 64'(reqc), 64'd0);
      @(negedge clk);

      // Backpressure: result must hold while the consumer stalls
      bus.i_ready = 1'b0;
      run_op(3'b000, 32'h1234_5678, 32'd8, lat, txn, reqc);
      chk("bp_result", 64'(bus.o_result), 64'h3456_7800);
      chk("bp_illegal_clear", 64'(bus.o_illegal), 64'd0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_valid_hold", 64'(bus.o_valid), 64'd1);
         chk("bp_result_hold", 64'(bus.o_result), 64'h3456_7800);
         chk("bp_not_ready", 64'(bus.o_ready), 64'd0);
      end
      bus.i_ready = 1'b1;
      @(negedge clk);
      chk("bp_ready_after", 64'(bus.o_ready), 64'd1);
      chk("bp_valid_drop", 64'(bus.o_valid), 64'd0);

      // Flush on the cycle the first product returns
      start_op(3'b000, 32'h0000_0001, 32'd4);
      @(negedge clk);
      bus.i_flush = 1'b1;
      @(negedge clk);
      bus.i_flush = 1'b0;
      chk("flush_req_drop", 64'(bus.o_mul_req), 64'd0);
      chk("flush_no_valid", 64'(bus.o_valid), 64'd0);
      chk("flush_ready", 64'(bus.o_ready), 64'd1);
      vcnt = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (bus.o_valid || bus.o_mul_req) vcnt++;
      end
      chk("flush_quiet", 64'(vcnt), 64'd0);
      inject = 1'b1;
      @(negedge clk);
      inject = 1'b0;
      @(negedge clk);
      chk("late_product_ready", 64'(bus.o_ready), 64'd1);
      chk("late_product_no_valid", 64'(bus.o_valid), 64'd0);
      run_op(3'b001, 32'hF000_0000, 32'd4, lat, txn, reqc);
      chk("post_flush_srl", 64'(bus.o_result), 64'h0F00_0000);
      chk("post_flush_txn", 64'(txn), 64'd3);
      @(negedge clk);

      // Reset pulse mid-operation
      start_op(3'b010, 32'h8000_0000, 32'd31);
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk("rst_mid_req", 64'(bus.o_mul_req), 64'd0);
      chk("rst_mid_valid", 64'(bus.o_valid), 64'd0);
      chk("rst_mid_ready", 64'(bus.o_ready), 64'd1);
      chk("rst_mid_result", 64'(bus.o_result), 64'd0);
      chk("rst_mid_mul_a", 64'(bus.o_mul_operand_one), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_mid_quiet", 64'(bus.o_valid), 64'd0);
      run_op(3'b011, 32'h8000_0001, 32'd4, lat, txn, reqc);
      chk("post_rst_rol", 64'(bus.o_result), 64'h0000_0018);
      chk("post_rst_latency", 64'(lat), 64'd12);
      @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule

// File: doc/rv32_mul_shift_unit.md
Name: rv32_mul_shift_unit

Overview:
Parametrised multicycle shift/rotate execute unit that builds every shift as a multiplication by 2^k on the shared narrow multiplier IP, so no barrel shifter is needed. It supports SLL/SRL/SRA plus ROL/ROR, with configurable data and multiplier widths. Operands are captured on a valid/ready accept, and results are returned under backpressure. The unit sits in the execute stage beside the ALU and arbitrates nothing; it is the multiplier's sole requester while busy.

Parameters:
XLEN, 32, data width; must be a multiple of MUL_W
MUL_W, 16, multiplier IP operand width; product width 2*MUL_W
SHAMT_W, $clog2(XLEN), derived localparam, shift-amount width
NLIMB, 2*XLEN/MUL_W, derived localparam, limbs of extended operand

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_valid  in  1  request valid
o_ready  out  1  unit idle, can accept
i_op  in  3  000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR, others illegal
i_operand_one  in  XLEN  value to shift
i_operand_two  in  XLEN  shift amount; only [SHAMT_W-1:0] used
i_flush  in  1  synchronous abort
o_valid  out  1  result valid
i_ready  in  1  consumer accepts result
o_result  out  XLEN  result
o_illegal  out  1  qualifies o_valid: op was illegal
o_mul_req  out  1  multiplier request, level
o_mul_operand_one  out  MUL_W  limb of extended operand
o_mul_operand_two  out  MUL_W  power-of-two factor
i_mul_valid  in  1  one-cycle pulse, product valid
i_mul_result  in  2*MUL_W  product

Behaviour:
- Reset (async, i_rst_n=0): state IDLE; o_ready=1. o_valid, o_mul_req, o_illegal, o_result, and the multiplier operands are all 0. Reset mid-operation abandons the operation; no result is produced.
- States: IDLE -> ISSUE -> GAP -> ISSUE ... -> DONE -> IDLE.
- IDLE: o_ready=1. On i_valid, capture op, operand, and s=operand_two[SHAMT_W-1:0]; compute k, E, and j0 as below. Next state:
  - DONE if s==0 or op is illegal;
  - otherwise ISSUE with limb index i=0 and accumulator ACC=0.
- Extension and factor:
  - E (2*XLEN bits) = sign-extended operand for SRA, zero-extended otherwise.
  - k = s for SLL/ROL; k = XLEN-s for SRL/SRA/ROR.
  - j0 = k div MUL_W; r = k mod MUL_W.
- ISSUE: o_mul_req=1, o_mul_operand_one=E limb i, o_mul_operand_two=1<<r. Both operands are held stable while req is high.
  - On i_mul_valid: ACC += zero-extended i_mul_result << ((i+j0)*MUL_W), modulo 2^(2*XLEN). Then i increments.
  - If i was NLIMB-1-j0, go to DONE; else go to GAP.
- GAP: o_mul_req=0 for exactly one cycle, then ISSUE. Each operation therefore issues NLIMB-j0 transactions. i_mul_valid is ignored outside ISSUE.
- DONE: o_valid=1 and o_result is held stable until i_ready; the transfer completes in the cycle where o_valid&i_ready, and the next state is IDLE. Result selection:
  - s==0 -> operand unchanged;
  - SLL -> ACC[XLEN-1:0];
  - SRL/SRA -> ACC[2XLEN-1:XLEN];
  - ROL/ROR -> ACC[XLEN-1:0] | ACC[2XLEN-1:XLEN];
  - illegal -> o_result=0, o_illegal=1.
- o_illegal is 0 on every legal result.
- Latency, with accept at cycle T:
  - bypass/illegal: o_valid at T+1;
  - with a multiplier of fixed latency L, o_valid comes one cycle after the last i_mul_valid.
- i_flush: in any state, the next state is IDLE. o_mul_req and o_valid drop on the next edge, and any in-flight product is discarded. Flush beats a simultaneous accept: no capture occurs.
- Simultaneous events:
  - o_valid&i_ready in DONE returns the unit to IDLE; o_ready is never asserted in the same cycle as o_valid, so back-to-back issue costs one idle cycle.
  - A product returned in the same cycle as flush is discarded.

Test Plan:
- SLL 0x0000_0001 by 4 (1-cycle multiplier model) -> 4 transactions, o_mul_operand_two=0x0010, o_result=0x0000_0010, o_illegal=0.
- SRA 0x8000_0000 by 31 -> k=1, o_result=0xFFFF_FFFF. SRL of the same operand -> 0x0000_0001.
- ROR 0x0000_0001 by 1 -> k=31, j0=1, exactly 3 transactions, o_result=0x8000_0000. ROL 0x8000_0001 by 4 -> 0x0000_0018.
- Shift 0xDEAD_BEEF by 0, and op=111 -> o_valid at T+1, o_mul_req never asserted. Results are 0xDEAD_BEEF with o_illegal=0, and 0 with o_illegal=1.
- i_ready held low 5 cycles on SLL 0x1234_5678 by 8 -> o_valid/o_result=0x3456_7800 stable throughout; o_ready=1 the cycle after the handshake.
- Flush in cycle 3 of ISSUE, and separately i_rst_n pulsed low mid-operation -> o_mul_req=0 next cycle, no o_valid. A late i_mul_valid is ignored, and a following SRL 0xF000_0000 by 4 returns 0x0F00_0000.
